// File: rtl/demux_1_x_32_reg.sv
// Registered 1-to-4 demultiplexer: steers one input word per transfer into one of four
// single-entry holding registers, each with its own valid/ready handshake and accept counter.
module demux_1_x_32_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       valid_q;
   logic [WIDTH-1:0] data_q [4];
   logic [CNT_W-1:0] cnt_q [4];
   logic [3:0]       free;
   logic [3:0]       wr_en;
   logic             accept;

   // A channel can take a new word if empty or being drained this very cycle.
   assign free     = ~valid_q | out_ready;
   assign in_ready = rst_n & free[in_sel];
   assign accept   = in_valid & in_ready;

   always_comb begin
      wr_en = '0;
      if (accept) begin
         wr_en[in_sel] = 1'b1;
      end
   end

   // A write wins over a drain on the same channel, so drain-and-refill creates no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
               data_q[k]  <= in_data;
               valid_q[k] <= 1'b1;
               cnt_q[k]   <= cnt_q[k] + CNT_ONE;
            end else if (out_ready[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = valid_q;
   assign busy      = |valid_q;
   assign out_data0 = data_q[0];
   assign out_data1 = data_q[1];
   assign out_data2 = data_q[2];
   assign out_data3 = data_q[3];
   assign cnt0      = cnt_q[0];
   assign cnt1      = cnt_q[1];
   assign cnt2      = cnt_q[2];
   assign cnt3      = cnt_q[3];

endmodule

// File: doc/demux_1_x_32_reg.md
Name: demux_1_x_32_reg

Overview:
- Registered 1-to-4 demultiplexer; the distributing counterpart of the 4-input 32-bit selector in the datapath.
- Accepts one 32-bit word plus a 2-bit destination select per transfer via a valid/ready handshake.
- Steers each word into one of four single-entry output holding registers, each with its own valid/ready handshake.
- Used where one producer (e.g. writeback/ALU result) feeds one of four consumers that may stall independently.

Parameters:
WIDTH, 32, data width of input and each output channel
CNT_W, 8, width of per-channel accepted-transfer counters (wrap-around)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word and sel are valid this cycle
in_ready  output  1  block accepts the input word this cycle
in_sel  input  2  destination channel 0..3
in_data  input  WIDTH  input word
out_valid  output  4  per-channel holding register occupied (bit k = channel k)
out_ready  input  4  per-channel consumer accepts word
out_data0..out_data3  output  WIDTH each  channel holding register contents
cnt0..cnt3  output  CNT_W each  words accepted into channel k since reset
busy  output  1  any out_valid bit set

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without clk): out_valid=0, out_data0..3=0, cnt0..3=0, busy=0. While reset is asserted in_ready=0.
- Input acceptance: accept = in_valid & in_ready. Words held in registers when reset asserts mid-operation are discarded.
- Channel k is free when out_valid[k]=0 or out_ready[k]=1. Draining and refilling in the same cycle is allowed.
- in_ready = rst_n & free[in_sel]. It is combinational from in_sel, out_valid and out_ready. It does not depend on in_valid.
- On the accept edge:
  - out_data{in_sel} <= in_data; out_valid[in_sel] <= 1.
  - cnt{in_sel} <= cnt{in_sel}+1, modulo 2^CNT_W; 2^CNT_W-1 wraps to 0.
- Latency: a word accepted at edge N is presented on out_data{sel} with out_valid set from edge N onward. That is one cycle of register latency, with no combinational path from in_data to out_data.
- Drain: out_valid[k] & out_ready[k] at an edge, with no accept to k at that edge -> out_valid[k] <= 0. out_data{k} holds its last value; it is not cleared.
- Simultaneous drain and accept on the same channel: out_valid[k] stays 1, out_data{k} takes the new word, and cnt{k} increments. No bubble is inserted.
- Activity on other channels:
  - Drains on channels other than in_sel proceed independently in the same cycle.
  - At most one channel is written per cycle.
- Blocked input: if the selected channel is full and not draining, in_ready=0.
  - The producer must hold in_valid, in_sel and in_data stable until accepted.
  - Other channels continue to drain.
- out_valid[k], once set, stays set until drained. out_data{k} is stable while out_valid[k]=1 and out_ready[k]=0.
- busy = |out_valid (combinational from registers).
- out_ready on an empty channel is ignored.
- in_sel is a 2-bit field, so every value is a legal channel; there is no default or drop path.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle with channel 2 holding 32'hB3 -> out_valid=4'b0000, out_data2=0, cnt2=0 immediately, with no clk edge required.
- Basic routing: send 32'd16,32'h4C,32'h2D,32'hB3 with sel 0,1,2,3 and all out_ready=0 -> out_valid=4'b1111, out_dataN match, cnt0..3=1.
- Backpressure: channel 1 full, out_ready=0, in_sel=1, in_valid=1 -> in_ready=0 for 3 cycles. Then raise out_ready[1] -> in_ready=1 that cycle, and the new word replaces the old one with out_valid[1] staying 1.
- Independence: channel 0 full and stalled, in_sel=3 -> in_ready=1, word accepted, out_valid=4'b1001.
- Streaming: out_ready[2] held 1, 10 back-to-back words to sel=2 -> in_ready stays 1, one word per cycle on out_data2, cnt2=10.
- Counter wrap: 256 accepts to channel 0 with CNT_W=8 -> cnt0 reads 255 then 0.
